// File: rtl/machine_alloc_pkg.sv
// Shared types and helpers for the machine power allocator.
package machine_alloc_pkg;

  localparam int MAX_MACH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Number of set bits in a (zero-padded) machine vector.
  function automatic logic [4:0] popcount(input logic [MAX_MACH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_MACH; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/machine_slot.sv
// One machine's power state: IDLE -> RUN on select, RUN -> COOL (or IDLE)
// on release, COOL holds for exactly COOLDOWN cycles ignoring req.
module machine_slot
  import machine_alloc_pkg::*;
#(
  parameter int COOLDOWN = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   select_i,
  input  logic   req_i,
  output state_e state_o,
  output logic   run_o
);

  localparam int CNTW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;

  // Per-machine FSM and cooldown counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (select_i) state_q <= RUN;
        RUN: begin
          if (!req_i) begin
            if (COOLDOWN == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= COOL;
              cnt_q   <= CNTW'(COOLDOWN - 1);
            end
          end
        end
        COOL: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CNTW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign run_o   = (state_q == RUN);

endmodule

// File: rtl/machine_power_allocator.sv
// Grants power to at most CAPACITY requesting machines, fixed-priority or
// round-robin, non-preemptive, with a per-machine cooldown after release.
module machine_power_allocator
  import machine_alloc_pkg::*;
#(
  parameter int  N_MACH   = 4,
  parameter int  CAPACITY = 2,
  parameter int  COOLDOWN = 3,
  localparam int CW       = $clog2(N_MACH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_MACH-1:0] req,
  input  logic              mode,
  output logic [N_MACH-1:0] grant,
  output logic [CW-1:0]     active_cnt,
  output logic              full,
  output logic [N_MACH-1:0] waiting
);

  localparam int PW = $clog2(N_MACH);

  if (N_MACH < 2 || N_MACH > MAX_MACH || CAPACITY < 1 || CAPACITY > N_MACH ||
      COOLDOWN < 0) begin : g_param_check
    $error("machine_power_allocator: illegal parameter values");
  end

  state_e            st [N_MACH];
  logic [N_MACH-1:0] run;
  logic [N_MACH-1:0] idle;
  logic [N_MACH-1:0] sel;
  logic [N_MACH-1:0] stay;
  logic [N_MACH-1:0] run_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q;
  logic              full_q;

  for (genvar i = 0; i < N_MACH; i++) begin : g_slot
    machine_slot #(.COOLDOWN(COOLDOWN)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .select_i (sel[i]),
      .req_i    (req[i]),
      .state_o  (st[i]),
      .run_o    (run[i])
    );
    assign idle[i] = (st[i] == IDLE);
  end

  // Slot accounting and selection scan; releases free their slot this cycle.
  always_comb begin
    int          free_w;
    int          taken;
    int          idx_w;
    logic [PW-1:0] idx;
    logic [PW-1:0] last;
    logic          any;
    stay   = run & req;
    free_w = CAPACITY - int'(popcount(MAX_MACH'(stay)));
    sel    = '0;
    taken  = 0;
    last   = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_MACH; k++) begin
      idx_w = k;
      if (mode == MODE_RR) begin
        idx_w = int'(ptr_q) + k;
        if (idx_w >= N_MACH) idx_w = idx_w - N_MACH;
      end
      idx = PW'(idx_w);
      if (req[idx] && idle[idx] && (taken < free_w)) begin
        sel[idx] = 1'b1;
        taken    = taken + 1;
        last     = idx;
        any      = 1'b1;
      end
    end
    run_d = stay | sel;
    ptr_d = ptr_q;
    if (any) ptr_d = (last == PW'(N_MACH - 1)) ? '0 : last + PW'(1);
  end

  // Round-robin pointer and registered count/full, aligned with grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= CW'(popcount(MAX_MACH'(run_d)));
      full_q <= (int'(popcount(MAX_MACH'(run_d))) == CAPACITY);
    end
  end

  assign grant      = run;
  assign active_cnt = cnt_q;
  assign full       = full_q;
  assign waiting    = rst_n ? (req & idle) : '0;

endmodule

// File: tb/tb_machine_power_allocator.sv
// Bench for machine_power_allocator: four parameterisations driven in
// lock-step against a cycle-level reference model of the allocation rules.
module tb_machine_power_allocator;

  logic        clk;
  logic        rst_n;
  logic [15:0] t_req  [4];
  logic        t_mode [4];

  logic [3:0] g_a, g_b, g_c, w_a, w_b, w_c;
  logic [7:0] g_d, w_d;
  logic [2:0] c_a, c_b, c_c;
  logic [3:0] c_d;
  logic       f_a, f_b, f_c, f_d;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: run flag, remaining blocked cycles, rotation pointer.
  int m_run  [4][16];
  int m_cool [4][16];
  int m_ptr  [4];
  int pn   [4] = '{4, 4, 4, 8};
  int pcap [4] = '{2, 2, 1, 3};
  int pcd  [4] = '{3, 0, 0, 3};

  machine_power_allocator #(.N_MACH(4), .CAPACITY(2), .COOLDOWN(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(t_req[0][3:0]), .mode(t_mode[0]),
    .grant(g_a), .active_cnt(c_a), .full(f_a), .waiting(w_a));
  machine_power_allocator #(.N_MACH(4), .CAPACITY(2), .COOLDOWN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(t_req[1][3:0]), .mode(t_mode[1]),
    .grant(g_b), .active_cnt(c_b), .full(f_b), .waiting(w_b));
  machine_power_allocator #(.N_MACH(4), .CAPACITY(1), .COOLDOWN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(t_req[2][3:0]), .mode(t_mode[2]),
    .grant(g_c), .active_cnt(c_c), .full(f_c), .waiting(w_c));
  machine_power_allocator #(.N_MACH(8), .CAPACITY(3), .COOLDOWN(3)) dut_d (
    .clk(clk), .rst_n(rst_n), .req(t_req[3][7:0]), .mode(t_mode[3]),
    .grant(g_d), .active_cnt(c_d), .full(f_d), .waiting(w_d));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dut_grant(input int u);
    case (u)
      0: return {12'b0, g_a};
      1: return {12'b0, g_b};
      2: return {12'b0, g_c};
      default: return {8'b0, g_d};
    endcase
  endfunction

  function automatic logic [15:0] dut_wait(input int u);
    case (u)
      0: return {12'b0, w_a};
      1: return {12'b0, w_b};
      2: return {12'b0, w_c};
      default: return {8'b0, w_d};
    endcase
  endfunction

  function automatic logic [15:0] dut_cnt(input int u);
    case (u)
      0: return {13'b0, c_a};
      1: return {13'b0, c_b};
      2: return {13'b0, c_c};
      default: return {12'b0, c_d};
    endcase
  endfunction

  function automatic logic [15:0] dut_full(input int u);
    case (u)
      0: return {15'b0, f_a};
      1: return {15'b0, f_b};
      2: return {15'b0, f_c};
      default: return {15'b0, f_d};
    endcase
  endfunction

  function automatic logic [15:0] exp_grant(input int u);
    logic [15:0] v = '0;
    for (int i = 0; i < pn[u]; i++) v[i] = (m_run[u][i] != 0);
    return v;
  endfunction

  function automatic logic [15:0] exp_wait(input int u);
    logic [15:0] v = '0;
    for (int i = 0; i < pn[u]; i++)
      v[i] = t_req[u][i] && (m_run[u][i] == 0) && (m_cool[u][i] == 0);
    return v;
  endfunction

  function automatic int exp_cnt(input int u);
    int c = 0;
    for (int i = 0; i < pn[u]; i++) c += m_run[u][i];
    return c;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 4; u++) begin
      m_ptr[u] = 0;
      for (int i = 0; i < 16; i++) begin
        m_run[u][i]  = 0;
        m_cool[u][i] = 0;
      end
    end
  endtask

  // Advance one instance by one clock edge using the current inputs.
  task automatic model_step(input int u);
    int elig [16];
    int stay, freec, lastg, anyg, idx;
    stay = 0;
    for (int i = 0; i < pn[u]; i++) begin
      elig[i] = (t_req[u][i] && m_run[u][i] == 0 && m_cool[u][i] == 0) ? 1 : 0;
      if (m_run[u][i] != 0 && t_req[u][i]) stay++;
    end
    for (int i = 0; i < pn[u]; i++) begin
      if (m_run[u][i] != 0 && !t_req[u][i]) begin
        m_run[u][i]  = 0;
        m_cool[u][i] = pcd[u];
      end else if (m_cool[u][i] > 0) begin
        m_cool[u][i]--;
      end
    end
    freec = pcap[u] - stay;
    anyg  = 0;
    lastg = 0;
    for (int k = 0; k < pn[u]; k++) begin
      idx = t_mode[u] ? (m_ptr[u] + k) % pn[u] : k;
      if (elig[idx] != 0 && freec > 0) begin
        m_run[u][idx] = 1;
        freec--;
        lastg = idx;
        anyg  = 1;
      end
    end
    if (anyg != 0) m_ptr[u] = (lastg + 1) % pn[u];
  endtask

  // Scoreboard comparison point.
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("%s u%0d grant", tag, u), dut_grant(u), exp_grant(u));
      chk($sformatf("%s u%0d waiting", tag, u), dut_wait(u), exp_wait(u));
      chk($sformatf("%s u%0d active_cnt", tag, u), dut_cnt(u), 16'(exp_cnt(u)));
      chk($sformatf("%s u%0d full", tag, u), dut_full(u), {15'b0, exp_cnt(u) == pcap[u]});
    end
  endtask

  // One clock edge: model and DUT advance together, then compare.
  task automatic tick(input string tag);
    for (int u = 0; u < 4; u++) model_step(u);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] p;
    logic [3:0] tt;
    rst_n = 1'b0;
    for (int u = 0; u < 4; u++) begin
      t_req[u]  = '0;
      t_mode[u] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");

    // Plan 1: all four request from reset.
    t_req[0] = 16'h000f;
    tick("p1");
    chk("p1 grant", dut_grant(0), 16'h0003);
    chk("p1 cnt", dut_cnt(0), 16'd2);
    chk("p1 full", dut_full(0), 16'd1);
    chk("p1 waiting", dut_wait(0), 16'h000c);

    // Plan 2: release m0, m2 takes the slot on the same edge; m0 cools.
    t_req[0] = 16'h000e;
    tick("p2a");
    chk("p2 grant", dut_grant(0), 16'h0006);
    chk("p2 waiting", dut_wait(0), 16'h0008);
    t_req[0] = 16'h000f;
    tick("p2b");
    chk("p2 cool grant", dut_grant(0), 16'h0006);
    chk("p2 cool waiting", dut_wait(0), 16'h0008);
    tick("p2c");
    tick("p2d");
    chk("p2 idle waiting", dut_wait(0), 16'h0009);
    t_req[0] = 16'h000d;
    tick("p2e");
    chk("p2 regrant", dut_grant(0), 16'h0005);

    // Plan 3: non-preemption on the no-cooldown instance.
    t_req[1] = 16'h0008;
    tick("p3a");
    tick("p3b");
    chk("p3 alone", dut_grant(1), 16'h0008);
    t_req[1] = 16'h000f;
    tick("p3c");
    chk("p3 keep", dut_grant(1), 16'h0009);

    // Plan 6: static sweep against the original four-machine truth table.
    for (int pat = 0; pat < 16; pat++) begin
      t_req[1] = 16'h0000;
      tick("p6 clr");
      t_req[1] = 16'(pat);
      tick("p6 a");
      tick("p6 b");
      p = 4'(pat);
      tt[0] = p[0];
      tt[1] = p[1];
      tt[2] = p[2] & ~(p[0] & p[1]);
      tt[3] = p[3] & ((int'(p[0]) + int'(p[1]) + int'(p[2])) < 2);
      chk($sformatf("p6 table %h", p), dut_grant(1), {12'b0, tt});
    end

    // Plan 4: round-robin rotation with a single slot.
    t_mode[2] = 1'b1;
    t_req[2]  = 16'h000f;
    tick("p4 start");
    chk("p4 rr 0", dut_grant(2), 16'h0001);
    for (int s = 1; s <= 4; s++) begin
      t_req[2] = 16'h000f & ~(16'h0001 << (s - 1));
      tick("p4 step");
      chk($sformatf("p4 rr %0d", s), dut_grant(2), 16'h0001 << (s % 4));
    end

    // Plan 5: eight simultaneous requests, three slots.
    t_req[3] = 16'h00ff;
    tick("p5");
    chk("p5 grant", dut_grant(3), 16'h0007);
    chk("p5 cnt", dut_cnt(3), 16'd3);

    // Randomised traffic on every instance.
    for (int c = 0; c < 300; c++) begin
      for (int u = 0; u < 4; u++) begin
        t_req[u]  = 16'($urandom_range(0, (1 << pn[u]) - 1));
        t_mode[u] = 1'($urandom_range(0, 1));
      end
      tick("rand");
    end

    // Asynchronous reset in the middle of a cycle.
    for (int u = 0; u < 4; u++) t_req[u] = 16'((1 << pn[u]) - 1);
    tick("pre rst");
    chk("pre rst grant d", dut_grant(3) == 16'h0 ? 16'h1 : 16'h0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("async rst u%0d grant", u), dut_grant(u), 16'h0);
      chk($sformatf("async rst u%0d cnt", u), dut_cnt(u), 16'h0);
      chk($sformatf("async rst u%0d full", u), dut_full(u), 16'h0);
      chk($sformatf("async rst u%0d waiting", u), dut_wait(u), 16'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick("post rst");
    chk("post rst grant d", dut_grant(3), 16'h0007);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
